// File: rtl/series_eval_engine.sv
// Iterative fixed-point series evaluator for exp(x) / exp(-x): one multiply per MULX/MULC state, one add per ACC.
// Define SERIES_SAT_EN to saturate products and sums and report overflow on ovf; otherwise arithmetic wraps.
module series_eval_engine #(
    parameter int W         = 16,
    parameter int FRAC      = 8,
    parameter int MAX_TERMS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] thr,
    input  logic         alt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] ans,
    output logic [4:0]   terms,
    output logic         ovf,
    output logic [2:0]   dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
    // and the source holds its payload stable while valid is high and ready is low.
    typedef enum logic [2:0] {IDLE, MULX, MULC, ACC, DONE} state_t;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FRAC;

    state_t         state, state_nx;
    logic [W-1:0]   x_r, thr_r, tmp, ans_r;
    logic           alt_r;
    logic [4:0]     k;
    logic [W-1:0]   coef [16];
    logic [W-1:0]   mul_op, tmp_nx, acc_nx, diff;
    logic [2*W-1:0] prod;
    logic [W:0]     sum;
    logic           sub_en, last, accept;

    // c[k] = floor(1.0 / (k+1)) in the operand format, fixed at elaboration
    for (genvar i = 0; i < 16; i++) begin : g_coef
        localparam int unsigned CI = (32'd1 << FRAC) / (i + 1);
        assign coef[i] = W'(CI);
    end

    assign accept = (state == IDLE) && in_valid;
    assign mul_op = (state == MULX) ? x_r : coef[k[3:0]];
    assign prod   = {{W{1'b0}}, tmp} * {{W{1'b0}}, mul_op};
    assign sum    = {1'b0, ans_r} + {1'b0, tmp};
    assign diff   = ans_r - tmp;
    assign sub_en = alt_r && !k[0];
    assign last   = ((k + 5'd1) == 5'(MAX_TERMS)) || (tmp < thr_r);

`ifdef SERIES_SAT_EN
    logic prod_hi, acc_ovf, ovf_r;
    logic unused_bits;
    assign prod_hi     = |prod[2*W-1:W+FRAC];
    assign tmp_nx      = prod_hi ? '1 : prod[W+FRAC-1:FRAC];
    assign acc_nx      = sub_en ? ((ans_r < tmp) ? '0 : diff) : (sum[W] ? '1 : sum[W-1:0]);
    assign acc_ovf     = sub_en ? (ans_r < tmp) : sum[W];
    assign unused_bits = ^prod[FRAC-1:0];

    // Sticky until the next request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         ovf_r <= 1'b0;
        else if (accept)                                    ovf_r <= 1'b0;
        else if ((state == MULX || state == MULC) && prod_hi) ovf_r <= 1'b1;
        else if (state == ACC && acc_ovf)                   ovf_r <= 1'b1;
    end
    assign ovf = ovf_r;
`else
    logic unused_bits;
    assign tmp_nx      = prod[W+FRAC-1:FRAC];
    assign acc_nx      = sub_en ? diff : sum[W-1:0];
    assign unused_bits = ^{prod[2*W-1:W+FRAC], prod[FRAC-1:0], sum[W]};
    assign ovf         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = MULX;
            MULX:    state_nx = MULC;
            MULC:    state_nx = ACC;
            ACC:     state_nx = last ? DONE : MULX;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r   <= '0;
            thr_r <= '0;
            alt_r <= 1'b0;
            tmp   <= '0;
            ans_r <= '0;
            k     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_r   <= x;
                    thr_r <= thr;
                    alt_r <= alt;
                    tmp   <= ONE;
                    ans_r <= ONE;
                    k     <= '0;
                end
                MULX, MULC: tmp <= tmp_nx;
                ACC: begin
                    ans_r <= acc_nx;
                    k     <= k + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign ans   = ans_r;
    assign terms = k;
endmodule
